pixel_color_encoder: RTL and testbench

//  Encoder side of the 8-bit colour-code format consumed by the register-file colour decoder.

---
 rtl/pixel_color_encoder_if.sv | 30 +++
 rtl/pixel_color_encoder.sv | 199 +++++++++++++++++++
 tb/tb_pixel_color_encoder.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pixel_color_encoder_if.sv
`default_nettype none
// ============================================================================
// Module   : pixel_color_encoder_if
// Purpose  : Word-in / code-out stream bundle of the pixel colour encoder.
//            master = upstream word source plus downstream code sink
//            slave  = the encoder itself
// Revision : 1.0  initial release
// ============================================================================
interface pixel_color_encoder_if;
   logic        in_valid;
   logic        in_ready;
   logic [47:0] in_data;
   logic [7:0]  in_alpha;
   logic        in_last;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_code;
   logic        out_last;

   modport master (
      output in_valid, in_data, in_alpha, in_last, out_ready,
      input  in_ready, out_valid, out_code, out_last
   );

   modport slave (
      input  in_valid, in_data, in_alpha, in_last, out_ready,
      output in_ready, out_valid, out_code, out_last
   );
endinterface
`default_nettype wire

// File: rtl/pixel_color_encoder.sv
`default_nettype none
// ============================================================================
// Module   : pixel_color_encoder
// Purpose  : Quantizes packed two-pixel RGB words plus alpha into 8-bit
//            {B,G,R,A} colour codes and serializes them, pixel1 first, onto a
//            valid/ready stream. pix_cnt counts delivered codes per frame.
// Options  : COLOR_ERR_DIFFUSE_EN - per-channel (R,G,B) error diffusion
// Revision : 1.0  initial release
// ============================================================================
module pixel_color_encoder #(
   parameter int PIX_CNT_W = 16
) (
   input  wire                  clk,
   input  wire                  rst_n,
   pixel_color_encoder_if.slave bus,
   output logic [PIX_CNT_W-1:0] pix_cnt
);

   localparam logic [1:0] c_IDLE    = 2'd0;
   localparam logic [1:0] c_EMIT_HI = 2'd1;
   localparam logic [1:0] c_EMIT_LO = 2'd2;

   // Channel value to 2-bit code, fixed decision thresholds 32/128/224.
   function automatic logic [1:0] f_quant_ch(input logic [7:0] v);
      logic [1:0] q;
      if (v < 8'd32)       q = 2'b00;
      else if (v < 8'd128) q = 2'b01;
      else if (v < 8'd224) q = 2'b10;
      else                 q = 2'b11;
      return q;
   endfunction

   // Alpha value to 2-bit code, thresholds 13/38/63.
   function automatic logic [1:0] f_quant_alpha(input logic [7:0] v);
      logic [1:0] q;
      if (v < 8'd13)      q = 2'b00;
      else if (v < 8'd38) q = 2'b01;
      else if (v < 8'd63) q = 2'b10;
      else                q = 2'b11;
      return q;
   endfunction

   logic [1:0]           r_state;
   logic [23:0]          r_pix0;
   logic [1:0]           r_alpha_q;
   logic                 r_last;
   logic [7:0]           r_code;
   logic                 r_last_out;
   logic [PIX_CNT_W-1:0] r_pix_cnt;

   logic                 w_out_valid;
   logic                 w_in_ready;
   logic                 w_accept;
   logic                 w_hs;
   logic                 w_load;
   logic [23:0]          w_pix;
   logic [1:0]           w_alpha_q;
   logic [7:0]           w_e [3];
   logic [7:0]           w_code;

   // Stream handshakes; the input side reopens while the final code of a
   // word is being taken so words can follow each other without a bubble.
   assign w_out_valid = (r_state == c_EMIT_HI) || (r_state == c_EMIT_LO);
   assign w_in_ready  = (r_state == c_IDLE) || ((r_state == c_EMIT_LO) && bus.out_ready);
   assign w_accept    = bus.in_valid && w_in_ready;
   assign w_hs        = w_out_valid && bus.out_ready;
   assign w_load      = w_accept || ((r_state == c_EMIT_HI) && bus.out_ready);

   // A freshly accepted word supplies pixel1 straight from the bus; otherwise
   // the held pixel0 is the next one to encode.
   assign w_pix     = w_accept ? bus.in_data[47:24] : r_pix0;
   assign w_alpha_q = w_accept ? f_quant_alpha(bus.in_alpha) : r_alpha_q;

`ifdef COLOR_ERR_DIFFUSE_EN
   // Residual level of each code: nominal reconstruction levels 0/63/191/255.
   function automatic logic [7:0] f_level(input logic [1:0] c);
      logic [7:0] l;
      case (c)
         2'b00:   l = 8'd0;
         2'b01:   l = 8'd63;
         2'b10:   l = 8'd191;
         default: l = 8'd255;
      endcase
      return l;
   endfunction

   logic signed [8:0] r_res [3];
   logic [7:0]        r_e [3];
   logic signed [8:0] w_res_eff [3];
   logic [9:0]        w_sum [3];

   // Residual as it stands after this edge, folded into the pixel being
   // loaded so a code loaded on a handshake sees the freshly updated error.
   always_comb begin
      for (int c = 0; c < 3; c++) begin
         w_res_eff[c] = r_res[c];
         if (w_hs) begin
            if (r_last_out) begin
               w_res_eff[c] = '0;
            end else begin
               w_res_eff[c] = $signed({1'b0, r_e[c]})
                            - $signed({1'b0, f_level(r_code[2*c+2 +: 2])});
            end
         end
         w_sum[c] = {2'b00, w_pix[23-8*c -: 8]} + {w_res_eff[c][8], w_res_eff[c]};
         if (w_sum[c][9])      w_e[c] = 8'd0;
         else if (w_sum[c][8]) w_e[c] = 8'hFF;
         else                  w_e[c] = w_sum[c][7:0];
      end
   end

   // Residual and diffused-value registers; both restart from zero on reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int c = 0; c < 3; c++) begin
            r_res[c] <= '0;
            r_e[c]   <= '0;
         end
      end else begin
         for (int c = 0; c < 3; c++) begin
            r_res[c] <= w_res_eff[c];
            if (w_load) begin
               r_e[c] <= w_e[c];
            end
         end
      end
   end
`else
   // Plain nearest-level quantization: channels feed the quantizer directly.
   always_comb begin
      for (int c = 0; c < 3; c++) begin
         w_e[c] = w_pix[23-8*c -: 8];
      end
   end
`endif

   assign w_code = {f_quant_ch(w_e[2]), f_quant_ch(w_e[1]),
                    f_quant_ch(w_e[0]), w_alpha_q};

   // Control FSM plus word holding and code output registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= c_IDLE;
         r_pix0     <= '0;
         r_alpha_q  <= '0;
         r_last     <= 1'b0;
         r_code     <= '0;
         r_last_out <= 1'b0;
      end else if (w_accept) begin
         r_state    <= c_EMIT_HI;
         r_pix0     <= bus.in_data[23:0];
         r_alpha_q  <= f_quant_alpha(bus.in_alpha);
         r_last     <= bus.in_last;
         r_code     <= w_code;
         r_last_out <= 1'b0;
      end else begin
         case (r_state)
            c_IDLE: begin
               r_state <= c_IDLE;
            end
            c_EMIT_HI: begin
               if (bus.out_ready) begin
                  r_state    <= c_EMIT_LO;
                  r_code     <= w_code;
                  r_last_out <= r_last;
               end
            end
            c_EMIT_LO: begin
               if (bus.out_ready) begin
                  r_state    <= c_IDLE;
                  r_last_out <= 1'b0;
               end
            end
            default: begin
               r_state    <= c_IDLE;
               r_last_out <= 1'b0;
            end
         endcase
      end
   end

   // Delivered-code counter; an end-of-frame code restarts it at zero.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_pix_cnt <= '0;
      end else if (w_hs) begin
         if (r_last_out) r_pix_cnt <= '0;
         else            r_pix_cnt <= r_pix_cnt + 1'b1;
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = w_out_valid;
   assign bus.out_code  = r_code;
   assign bus.out_last  = r_last_out;
   assign pix_cnt       = r_pix_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pixel_color_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_pixel_color_encoder
// Purpose  : Self-checking bench for pixel_color_encoder (4-bit pix_cnt).
// Revision : 1.0  initial release
// ============================================================================
module tb_pixel_color_encoder;

   localparam int PW = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [PW-1:0] pix_cnt;

   pixel_color_encoder_if bus();

   pixel_color_encoder #(.PIX_CNT_W(PW)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .bus     (bus),
      .pix_cnt (pix_cnt)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [7:0] code;
      logic       last;
   } exp_t;

   exp_t q[$];
   int   m_cnt = 0;
   int   res[3] = '{0, 0, 0};
   bit   mon_en = 1'b0;

   function automatic int qch(input int v);
      if (v < 32)  return 0;
      if (v < 128) return 1;
      if (v < 224) return 2;
      return 3;
   endfunction

   function automatic int qa(input int v);
      if (v < 13) return 0;
      if (v < 38) return 1;
      if (v < 63) return 2;
      return 3;
   endfunction

   function automatic int lvl(input int k);
      case (k)
         0:       return 0;
         1:       return 63;
         2:       return 191;
         default: return 255;
      endcase
   endfunction

   task automatic model_push(input logic [47:0] d, input logic [7:0] a, input logic last);
      for (int p = 1; p >= 0; p--) begin
         int   code;
         exp_t x;
         code = qa(int'(a));
         for (int c = 0; c < 3; c++) begin
            int v;
            int e;
            int k;
            v = int'(d[p*24 + 16 - 8*c +: 8]);
            e = v;
`ifdef COLOR_ERR_DIFFUSE_EN
            e = v + res[c];
            if (e < 0)   e = 0;
            if (e > 255) e = 255;
`endif
            k = qch(e);
            res[c] = e - lvl(k);
            code = code + (k << (2 + 2*c));
         end
         x.code = 8'(code);
         x.last = (p == 0) ? last : 1'b0;
         q.push_back(x);
         if (p == 0 && last) res = '{0, 0, 0};
      end
   endtask

   // Stream monitor: every cycle compares DUT against the model.
   always @(negedge clk) begin
      if (mon_en) begin
         chk("mon_out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
         chk("mon_in_ready", 32'(bus.in_ready),
             32'((q.size() == 0) || (q.size() == 1 && bus.out_ready)));
         chk("mon_pix_cnt", 32'(pix_cnt), 32'(m_cnt));
         if (bus.out_valid && q.size() != 0) begin
            chk("mon_code", 32'(bus.out_code), 32'(q[0].code));
            chk("mon_last", 32'(bus.out_last), 32'(q[0].last));
         end
         if (!rst_n) begin
            q.delete();
            m_cnt = 0;
            res = '{0, 0, 0};
         end else begin
            if (bus.out_valid && bus.out_ready && q.size() != 0) begin
               m_cnt = q[0].last ? 0 : (m_cnt + 1) % (1 << PW);
               void'(q.pop_front());
            end
            if (bus.in_valid && bus.in_ready) model_push(bus.in_data, bus.in_alpha, bus.in_last);
         end
      end
   end

   // ---------------- directed helpers ----------------
   typedef struct {
      logic [47:0] data;
      logic [7:0]  alpha;
      logic        last;
      logic [7:0]  hi;
      logic [7:0]  lo;
   } vec_t;

   vec_t vecs[7];

   // Sends one word into an idle DUT with out_ready high, checks both codes.
   task automatic send_and_check(input vec_t v, input string name);
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_data   = v.data;
      bus.in_alpha  = v.alpha;
      bus.in_last   = v.last;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk({name, "_hi_valid"}, 32'(bus.out_valid), 32'd1);
      chk({name, "_hi_code"}, 32'(bus.out_code), 32'(v.hi));
      chk({name, "_hi_last"}, 32'(bus.out_last), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk({name, "_lo_valid"}, 32'(bus.out_valid), 32'd1);
      chk({name, "_lo_code"}, 32'(bus.out_code), 32'(v.lo));
      chk({name, "_lo_last"}, 32'(bus.out_last), 32'(v.last));
      @(posedge clk); #1;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        v;
      logic [47:0] words[3];
      logic [63:0] rnd;
      exp_t        got[$];
      int          gcyc[$];
      int          widx;
      int          acc;
      bit          a;

      vecs[0] = '{48'hFFBF3F_000000, 8'd50,  1'b0, 8'h6E, 8'h02};
      vecs[1] = '{48'h1F207F_80DFE0, 8'd12,  1'b0, 8'h50, 8'hE8};
      vecs[2] = '{48'h1F207F_80DFE0, 8'd13,  1'b0, 8'h51, 8'hE9};
      vecs[3] = '{48'h000000_FFFFFF, 8'd37,  1'b0, 8'h01, 8'hFD};
      vecs[4] = '{48'h000000_FFFFFF, 8'd38,  1'b0, 8'h02, 8'hFE};
      vecs[5] = '{48'hE08020_00FF64, 8'd63,  1'b1, 8'h6F, 8'h73};
      vecs[6] = '{48'h000000_000000, 8'd255, 1'b0, 8'h03, 8'h03};

      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_alpha  = '0;
      bus.in_last   = 1'b0;
      bus.out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_out_code", 32'(bus.out_code), 32'd0);
      chk("rst_out_last", 32'(bus.out_last), 32'd0);
      chk("rst_pix_cnt", 32'(pix_cnt), 32'd0);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
      mon_en = 1'b1;
      @(posedge clk); #1;

      // Table of threshold/layout vectors (plain quantization values).
`ifndef COLOR_ERR_DIFFUSE_EN
      for (int i = 0; i < 7; i++) begin
         send_and_check(vecs[i], $sformatf("vec%0d", i));
      end
`endif

      // Stall during EMIT_HI: code held, input blocked.
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_data   = vecs[0].data;
      bus.in_alpha  = vecs[0].alpha;
      bus.in_last   = 1'b0;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stall_code", 32'(bus.out_code), 32'h6E);
         chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
         @(posedge clk); #1;
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk("stall_hi", 32'(bus.out_code), 32'h6E);
      @(posedge clk); #1;
      @(negedge clk);
      chk("stall_lo", 32'(bus.out_code), 32'h02);
      @(posedge clk); #1;
      @(negedge clk);
      chk("stall_done", 32'(bus.out_valid), 32'd0);
      @(posedge clk); #1;

      // Back-to-back words: six codes on consecutive cycles, last on sixth.
      words[0] = 48'hFFBF3F_000000;
      words[1] = 48'h1F207F_80DFE0;
      words[2] = 48'h000000_FFFFFF;
      widx = 0;
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_data   = words[0];
      bus.in_alpha  = 8'd50;
      bus.in_last   = 1'b0;
      for (int cyc = 0; cyc < 20 && got.size() < 6; cyc++) begin
         exp_t x;
         @(negedge clk);
         if (bus.out_valid) begin
            x.code = bus.out_code;
            x.last = bus.out_last;
            got.push_back(x);
            gcyc.push_back(cyc);
         end
         if (bus.in_valid && bus.in_ready) widx++;
         @(posedge clk); #1;
         if (widx >= 3) begin
            bus.in_valid = 1'b0;
            bus.in_last  = 1'b0;
         end else begin
            bus.in_data = words[widx];
            bus.in_last = (widx == 2);
         end
      end
      chk("b2b_count", 32'(got.size()), 32'd6);
      for (int i = 0; i < got.size(); i++) begin
         chk("b2b_gap", 32'(gcyc[i] - gcyc[0]), 32'(i));
         chk("b2b_last", 32'(got[i].last), 32'(i == 5));
      end
      @(negedge clk);
      chk("b2b_pix_cnt", 32'(pix_cnt), 32'd0);
      @(posedge clk); #1;

      // Nine words without last: 18 codes, 4-bit counter wraps to 2.
      acc = 0;
      bus.in_valid = 1'b1;
      bus.in_last  = 1'b0;
      for (int cyc = 0; cyc < 60 && acc < 9; cyc++) begin
         @(negedge clk);
         if (bus.in_valid && bus.in_ready) acc++;
         @(posedge clk); #1;
         rnd = {$urandom, $urandom};
         bus.in_data = rnd[47:0];
         if (acc >= 9) bus.in_valid = 1'b0;
      end
      bus.in_valid = 1'b0;
      for (int cyc = 0; cyc < 10 && bus.out_valid; cyc++) @(posedge clk);
      #1;
      @(negedge clk);
      chk("wrap_words", 32'(acc), 32'd9);
      chk("wrap_pix_cnt", 32'(pix_cnt), 32'd2);
      @(posedge clk); #1;

      // Reset while EMIT_HI is waiting, then a clean word.
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_data   = vecs[0].data;
      bus.in_alpha  = 8'd50;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("mid_valid_before", 32'(bus.out_valid), 32'd1);
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("mid_out_valid", 32'(bus.out_valid), 32'd0);
      chk("mid_pix_cnt", 32'(pix_cnt), 32'd0);
      chk("mid_in_ready", 32'(bus.in_ready), 32'd1);
      @(posedge clk); #1;
      v.data  = 48'h280000_280000;
      v.alpha = 8'd0;
      v.last  = 1'b0;
      v.hi    = 8'h04;
`ifdef COLOR_ERR_DIFFUSE_EN
      v.lo    = 8'h00;
`else
      v.lo    = 8'h04;
`endif
      send_and_check(v, "post_rst");

      // Randomized traffic against the model.
      bus.in_valid = 1'b0;
      for (int cyc = 0; cyc < 800; cyc++) begin
         @(negedge clk);
         a = bus.in_valid && bus.in_ready;
         @(posedge clk); #1;
         if (a || !bus.in_valid) begin
            rnd = {$urandom, $urandom};
            bus.in_valid = ($urandom_range(0, 3) != 0);
            bus.in_data  = rnd[47:0];
            bus.in_alpha = 8'($urandom_range(0, 255));
            bus.in_last  = ($urandom_range(0, 7) == 0);
         end
         bus.out_ready = ($urandom_range(0, 3) != 0);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      for (int cyc = 0; cyc < 20 && q.size() != 0; cyc++) @(posedge clk);
      #1;
      @(negedge clk);
      chk("drain", 32'(q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
